// File: rtl/ami_slot_scheduler.sv
// rtl/ami_slot_scheduler.sv - round-robin word-slot scheduler feeding the AMI line encoder
// One load cycle plus WORD_W-1 shift cycles per slot; empty slots carry IDLE_WORD.
module ami_slot_scheduler #(
  parameter int                WORD_W    = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              run,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              enc_en,
  output logic [WORD_W-1:0] enc_data,
  output logic              slot_start,
  output logic [1:0]        slot_src,
  output logic              underrun,
  output logic [15:0]       word_cnt
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [CW-1:0] slot_cnt;
  logic          active;
  logic          rr_last;
  logic          load_cyc;
  logic          start;
  logic          grant_any;
  logic          grant_sel;

  always_comb begin
    load_cyc  = (slot_cnt == '0);
    start     = load_cyc & run & ~sys_rst;
    grant_any = start & (|req_valid);
    // with both requesters pending, the one not served last wins
    grant_sel = (&req_valid) ? ~rr_last : req_valid[1];
    req_ready = 2'b00;
    enc_data  = IDLE_WORD;
    if (grant_any) begin
      req_ready[grant_sel] = 1'b1;
      enc_data             = grant_sel ? req_data1 : req_data0;
    end
    enc_en     = ~load_cyc & ~sys_rst;
    slot_start = start;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      active   <= 1'b0;
      rr_last  <= 1'b1;
      slot_src <= 2'b00;
      underrun <= 1'b0;
      word_cnt <= 16'h0000;
    end else begin
      underrun <= 1'b0;
      if (!load_cyc) begin
        slot_cnt <= (slot_cnt == CW'(WORD_W - 1)) ? '0 : slot_cnt + CW'(1);
      end else if (run) begin
        slot_cnt <= CW'(1);
        active   <= 1'b1;
        if (grant_any) begin
          rr_last  <= grant_sel;
          word_cnt <= word_cnt + 16'h0001;
          slot_src <= grant_sel ? 2'b10 : 2'b01;
        end else begin
          slot_src <= 2'b00;
          underrun <= active;
        end
      end else begin
        active   <= 1'b0;
        slot_src <= 2'b00;
      end
    end
  end

endmodule
